// File: rtl/ped_request_unit.sv
// ped_request_unit: pedestrian pushbutton front end with REQ/ACK handshake and walk/don't-walk heads
// Ports: CLK, RST_N (async active-low), TICK (1 Hz strobe), PB1/PB2 (raw buttons),
//   G1/G2 (phase green), ACK1/ACK2 (request accepted), REQ1/REQ2 (pending requests),
//   WALK1/WALK2, DONTWALK1/DONTWALK2 (lamps), CHIRP1/CHIRP2 (only with PED_CHIRP_EN).
// Optional feature macro: PED_CHIRP_EN adds a registered chirp pulse on each TICK while walking.
module ped_crossing #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WALK_TIME       = 5,
  parameter int FLASH_TIME      = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pb,
  input  logic g,
  input  logic ack,
  output logic req,
  output logic walk,
`ifdef PED_CHIRP_EN
  output logic dontwalk,
  output logic chirp
`else
  output logic dontwalk
`endif
);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int TMAX = (WALK_TIME > FLASH_TIME) ? WALK_TIME : FLASH_TIME;
  localparam int CW   = $clog2(TMAX + 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WALK, S_FLASH} state_t;
  logic s1_q, s2_q, stable_q, stable_d, prev_q, press;
  logic [DW-1:0] db_q, db_d;
  logic req_q, req_d, walk_q, walk_d, dw_q, dw_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t st_q, st_d;
`ifdef PED_CHIRP_EN
  logic chirp_q, chirp_d;
  assign chirp_d = tick & g & (st_q == S_WALK);
  assign chirp   = chirp_q;
`endif
  // press fires one cycle after the debounced level rises, giving 2+DEBOUNCE+1 latency
  assign press = stable_q & ~prev_q;
  // ACK always wins: it clears a pending request and swallows a coincident press
  assign req_d = ack ? 1'b0 : (req_q | (press & (st_q == S_IDLE)));
  always_comb begin
    stable_d = stable_q;
    db_d     = '0;
    if (s2_q != stable_q) begin
      if (db_q == DW'(DEBOUNCE_CYCLES - 1)) stable_d = s2_q;
      else db_d = db_q + DW'(1);
    end
  end
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    walk_d = walk_q;
    dw_d   = dw_q;
    case (st_q)
      S_IDLE: begin
        walk_d = 1'b0;
        dw_d   = 1'b1;
        if (ack && req_q) st_d = S_WAIT;
      end
      S_WAIT: begin
        if (tick && g) begin
          st_d   = S_WALK;
          cnt_d  = CW'(WALK_TIME - 1);
          walk_d = 1'b1;
          dw_d   = 1'b0;
        end
      end
      S_WALK: begin
        if (!g) begin
          st_d   = S_IDLE;
          cnt_d  = '0;
          walk_d = 1'b0;
          dw_d   = 1'b1;
        end else if (tick) begin
          if (cnt_q == '0) begin
            st_d   = S_FLASH;
            cnt_d  = CW'(FLASH_TIME - 1);
            walk_d = 1'b0;
            dw_d   = 1'b1;
          end else cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        // losing green ends the clearance at once, same as the final tick
        if (!g || (tick && cnt_q == '0)) begin
          st_d   = S_IDLE;
          cnt_d  = '0;
          walk_d = 1'b0;
          dw_d   = 1'b1;
        end else if (tick) begin
          cnt_d = cnt_q - CW'(1);
          dw_d  = ~dw_q;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      db_q     <= '0;
      req_q    <= 1'b0;
      st_q     <= S_IDLE;
      cnt_q    <= '0;
      walk_q   <= 1'b0;
      dw_q     <= 1'b1;
`ifdef PED_CHIRP_EN
      chirp_q  <= 1'b0;
`endif
    end else begin
      s1_q     <= pb;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      db_q     <= db_d;
      req_q    <= req_d;
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      walk_q   <= walk_d;
      dw_q     <= dw_d;
`ifdef PED_CHIRP_EN
      chirp_q  <= chirp_d;
`endif
    end
  end
  assign req      = req_q;
  assign walk     = walk_q;
  assign dontwalk = dw_q;
endmodule

module ped_request_unit #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WALK_TIME       = 5,
  parameter int FLASH_TIME      = 3
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic TICK,
  input  logic PB1,
  input  logic PB2,
  input  logic G1,
  input  logic G2,
  input  logic ACK1,
  input  logic ACK2,
  output logic REQ1,
  output logic REQ2,
  output logic WALK1,
  output logic WALK2,
  output logic DONTWALK1,
`ifdef PED_CHIRP_EN
  output logic DONTWALK2,
  output logic CHIRP1,
  output logic CHIRP2
`else
  output logic DONTWALK2
`endif
);
  ped_crossing #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .WALK_TIME(WALK_TIME), .FLASH_TIME(FLASH_TIME)) u_x1 (
    .clk(CLK), .rst_n(RST_N), .tick(TICK), .pb(PB1), .g(G1), .ack(ACK1),
    .req(REQ1), .walk(WALK1),
`ifdef PED_CHIRP_EN
    .dontwalk(DONTWALK1), .chirp(CHIRP1)
`else
    .dontwalk(DONTWALK1)
`endif
  );
  ped_crossing #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .WALK_TIME(WALK_TIME), .FLASH_TIME(FLASH_TIME)) u_x2 (
    .clk(CLK), .rst_n(RST_N), .tick(TICK), .pb(PB2), .g(G2), .ack(ACK2),
    .req(REQ2), .walk(WALK2),
`ifdef PED_CHIRP_EN
    .dontwalk(DONTWALK2), .chirp(CHIRP2)
`else
    .dontwalk(DONTWALK2)
`endif
  );
endmodule

// File: tb/tb_ped_request_unit.sv
// tb_ped_request_unit: directed self-checking bench for ped_request_unit
module tb_ped_request_unit;
  logic CLK = 1'b0, RST_N = 1'b0, TICK = 1'b0;
  logic PB1 = 1'b0, PB2 = 1'b0, G1 = 1'b0, G2 = 1'b0, ACK1 = 1'b0, ACK2 = 1'b0;
  logic REQ1, REQ2, WALK1, WALK2, DONTWALK1, DONTWALK2;
  int checks = 0, errors = 0, req1_rises = 0;
`ifdef PED_CHIRP_EN
  logic CHIRP1, CHIRP2;
  int chirp1_cnt = 0;
  always @(negedge CLK) if (CHIRP1) chirp1_cnt++;
`endif
  ped_request_unit dut (
    .CLK(CLK), .RST_N(RST_N), .TICK(TICK), .PB1(PB1), .PB2(PB2), .G1(G1), .G2(G2),
    .ACK1(ACK1), .ACK2(ACK2), .REQ1(REQ1), .REQ2(REQ2), .WALK1(WALK1), .WALK2(WALK2),
`ifdef PED_CHIRP_EN
    .DONTWALK1(DONTWALK1), .DONTWALK2(DONTWALK2), .CHIRP1(CHIRP1), .CHIRP2(CHIRP2)
`else
    .DONTWALK1(DONTWALK1), .DONTWALK2(DONTWALK2)
`endif
  );
  always #5 CLK = ~CLK;
  always @(posedge REQ1) req1_rises++;
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic tick();
    step(2);
    TICK = 1'b1;
    step(1);
    TICK = 1'b0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    step(2);
    chk("rst_req1", REQ1, 0);
    chk("rst_walk1", WALK1, 0);
    chk("rst_dw1", DONTWALK1, 1);
    chk("rst_dw2", DONTWALK2, 1);
    RST_N = 1'b1;
    step(1);
    for (int i = 0; i < 14; i++) begin
      PB1 = ~PB1;
      step(3);
    end
    chk("bounce_no_req", REQ1, 0);
    PB1 = 1'b1;
    step(18);
    chk("bounce_req_early", REQ1, 0);
    step(1);
    chk("bounce_req_rise", REQ1, 1);
    G1 = 1'b1;
    ACK1 = 1'b1;
    step(1);
    ACK1 = 1'b0;
    chk("ack_clears_req", REQ1, 0);
    chk("wait_walk1", WALK1, 0);
    chk("wait_dw1", DONTWALK1, 1);
    tick();
    chk("walk_t0", WALK1, 1);
    chk("walk_t0_dw", DONTWALK1, 0);
    tick();
    tick();
    PB1 = 1'b0;
    step(20);
    PB1 = 1'b1;
    step(20);
    chk("press_in_walk_req", REQ1, 0);
    chk("press_in_walk_walk", WALK1, 1);
    tick();
    tick();
    chk("walk_t4", WALK1, 1);
    tick();
    chk("flash_walk1", WALK1, 0);
    chk("flash_dw_a", DONTWALK1, 1);
    tick();
    chk("flash_dw_b", DONTWALK1, 0);
    tick();
    chk("flash_dw_c", DONTWALK1, 1);
    tick();
    chk("idle_dw", DONTWALK1, 1);
    tick();
    chk("idle_dw_solid", DONTWALK1, 1);
    chk("idle_walk1", WALK1, 0);
    chk("req1_single_rise", req1_rises, 1);
`ifdef PED_CHIRP_EN
    chk("chirp1_count", chirp1_cnt, 5);
`endif
    PB1 = 1'b0;
    step(20);
    PB1 = 1'b1;
    step(18);
    ACK1 = 1'b1;
    step(1);
    ACK1 = 1'b0;
    chk("press_ack_same", REQ1, 0);
    step(3);
    chk("press_dropped", REQ1, 0);
    PB2 = 1'b1;
    step(19);
    chk("req2_rise", REQ2, 1);
    G2 = 1'b1;
    ACK2 = 1'b1;
    step(1);
    ACK2 = 1'b0;
    chk("req2_cleared", REQ2, 0);
    tick();
    chk("walk2_on", WALK2, 1);
    step(2);
    G2 = 1'b0;
    TICK = 1'b1;
    step(1);
    TICK = 1'b0;
    chk("override_walk2", WALK2, 0);
    chk("override_dw2", DONTWALK2, 1);
    G2 = 1'b1;
    tick();
    chk("override_idle", WALK2, 0);
    ACK2 = 1'b1;
    step(1);
    ACK2 = 1'b0;
    tick();
    chk("ack2_noreq_walk", WALK2, 0);
    chk("ack2_noreq_dw", DONTWALK2, 1);
    chk("ack2_noreq_req", REQ2, 0);
    PB1 = 1'b0;
    PB2 = 1'b0;
    step(20);
    PB1 = 1'b1;
    PB2 = 1'b1;
    step(19);
    chk("pre_rst_req1", REQ1, 1);
    chk("pre_rst_req2", REQ2, 1);
    ACK1 = 1'b1;
    step(1);
    ACK1 = 1'b0;
    tick();
    chk("pre_rst_walk1", WALK1, 1);
    #3;
    RST_N = 1'b0;
    #1;
    chk("async_walk1", WALK1, 0);
    chk("async_dw1", DONTWALK1, 1);
    chk("async_req2", REQ2, 0);
    step(1);
    RST_N = 1'b1;
    step(3);
    chk("post_rst_req2", REQ2, 0);
    chk("post_rst_walk1", WALK1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
